apb_gpio_bank: RTL and testbench
================================

Name: apb_gpio_bank

Overview:
- Parametrised APB3 GPIO peripheral; successor to the fixed 16-bit LED/switch slave.
- Provides a GPIO_W-bit output register with atomic set and clear aliases, and a synchronised input port.
- Provides per-bit rising-edge interrupt capture with enable masking, programmable wait states and PSLVERR error signalling.
- Sits on the APB bus behind the system APB master, driving board LEDs and sampling switches.

Parameters:
- GPIO_W, 16, GPIO width in bits; legal range 1..32.
- ADDR_W, 8, PADDR width.
- WAIT_STATES, 0, number of extra ACCESS cycles before PREADY; legal range 0..15.
- SYNC_STAGES, 2, flops in the input synchroniser; minimum 2.

Ports:
- PCLK  in  1  APB clock; all state is updated on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  ADDR_W  byte address; bits [1:0] are ignored.
- PSEL  in  1  slave select.
- PENABLE  in  1  ACCESS phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data; bits at or above GPIO_W are ignored.
- PRDATA  out  32  read data, zero-extended; 0 when not (PSEL&PENABLE&!PWRITE).
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY is high.
- GPIO_OUT  out  GPIO_W  output register.
- GPIO_IN  in  GPIO_W  asynchronous external inputs.
- IRQ  out  1  level interrupt.

Behaviour:
- Register map (offsets):
  - 0x00 OUT: RW.
  - 0x04 IN: RO; synchroniser output.
  - 0x08 SET: WO; OUT |= wdata.
  - 0x0C CLR: WO; OUT &= ~wdata.
  - 0x10 IEN: RW.
  - 0x14 ISTAT: RW1C.
  - 0x18 ID: RO; value 0x4750_0000 | GPIO_W.
- Reset values (asynchronous):
  - OUT, IEN, ISTAT, synchroniser flops, edge-history flop and wait counter are all 0.
  - Hence GPIO_OUT=0 and IRQ=0.
- Wait states:
  - A 4-bit counter wcnt increments each cycle that PSEL&PENABLE&(wcnt!=WAIT_STATES) holds.
  - wcnt clears whenever !(PSEL&PENABLE) or the transfer completes.
  - PREADY = PSEL&PENABLE&(wcnt==WAIT_STATES), so with WAIT_STATES=0 there is zero-wait access.
  - PREADY is 0 outside ACCESS.
- Commit:
  - Register writes take effect only on the edge where PSEL&PENABLE&PWRITE&PREADY&!PSLVERR; exactly once per transfer.
- PRDATA:
  - Combinational, and must be valid while PREADY is high.
  - Reading SET or CLR returns 0 with an OKAY response.
- PSLVERR:
  - Asserted with PREADY for an unmapped offset (0x1C and above) or a write to IN or ID.
  - No state changes on an error.
  - Reads of unmapped offsets return 0.
- Input path:
  - GPIO_IN passes through SYNC_STAGES flops; IN shows a change after SYNC_STAGES edges.
  - prev holds the last synchronised value.
  - rise = sync & ~prev.
  - After reset, an input that is already high produces one rise event (prev=0); this is intended.
- ISTAT:
  - Per bit, the next value is (ISTAT & ~clr) | rise, where clr = PWDATA bits on a committed write to 0x14.
  - A simultaneous rise and clear leaves the bit set (set wins).
  - Capture is independent of IEN.
- IRQ = |(ISTAT & IEN); combinational from registers.
- Simultaneous writes: one APB transfer at a time, so there is no register-level conflict; SET and CLR each act on the current OUT.
- Reset asserted mid-transfer: the transfer is aborted, wcnt returns to 0 and no partial write occurs.
- PSEL dropped before PREADY: wcnt clears and no write occurs.

Test Plan:
- GPIO_W=16, WAIT_STATES=0: write 0x00 := 0xFFFF_A5A5 → GPIO_OUT=0xA5A5, PREADY in the first ACCESS cycle; read 0x00 → PRDATA=0x0000_A5A5.
- OUT=0x00F0: write SET 0x000F → OUT=0x00FF; write CLR 0x00F0 → OUT=0x000F; read 0x08 → 0, PSLVERR=0.
- GPIO_IN=0x0003 applied asynchronously:
  - Read 0x04 two cycles later → 0x0003.
  - ISTAT=0x0003 the cycle after; IRQ=0 until IEN=0x0001 is written, then IRQ=1.
  - Write ISTAT=0x0001 → ISTAT=0x0002, IRQ=0.
- Hold GPIO_IN bit0 low→high on the exact edge a W1C of bit0 commits → ISTAT[0] remains 1.
- WAIT_STATES=3: read 0x18 → PREADY low for 3 ACCESS cycles, high on the 4th, PRDATA=0x4750_0010.
- Error cases:
  - Write 0x04, write 0x18 and read 0x20 → each gives PSLVERR=1 with PREADY and no register change.
  - Assert PRESETn low during a wait-state write to 0x00 → OUT=0, GPIO_OUT=0, wcnt=0.

Source files
------------

// File: rtl/apb_gpio_bank.sv
// APB3 GPIO bank: output register with set/clear aliases, synchronised inputs,
// per-bit rising-edge interrupt capture with enable mask, and programmable wait states.
module apb_gpio_bank #(
  parameter int GPIO_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [GPIO_W-1:0] GPIO_OUT,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic              IRQ
);

  localparam logic [2:0]  IDX_OUT   = 3'd0;
  localparam logic [2:0]  IDX_IN    = 3'd1;
  localparam logic [2:0]  IDX_SET   = 3'd2;
  localparam logic [2:0]  IDX_CLR   = 3'd3;
  localparam logic [2:0]  IDX_IEN   = 3'd4;
  localparam logic [2:0]  IDX_ISTAT = 3'd5;
  localparam logic [2:0]  IDX_ID    = 3'd6;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);
  localparam logic [31:0] ID_VALUE  = 32'h4750_0000 | 32'(GPIO_W);

  logic [31:0]       addr_s;
  logic [2:0]        idx_s;
  logic              unmapped_s;
  logic              err_s;
  logic              access_s;
  logic              ready_s;
  logic              commit_s;
  logic [GPIO_W-1:0] wdata_s;
  logic [GPIO_W-1:0] sync_out_s;
  logic [GPIO_W-1:0] rise_s;
  logic [GPIO_W-1:0] clr_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] ien_q, ien_d;
  logic [GPIO_W-1:0] istat_q, istat_d;
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q, sync_d;

  assign unused_s = ^{addr_s[1:0], PWDATA};

  // Address decode and transfer handshake; the error decision gates the commit.
  always_comb begin
    addr_s     = 32'(PADDR);
    idx_s      = addr_s[4:2];
    unmapped_s = (addr_s[31:5] != 27'd0) || (idx_s == 3'd7);
    err_s      = unmapped_s || (PWRITE && ((idx_s == IDX_IN) || (idx_s == IDX_ID)));
    access_s   = PSEL && PENABLE;
    ready_s    = access_s && (wcnt_q == WAIT_LAST);
    commit_s   = access_s && PWRITE && ready_s && !err_s;
    wdata_s    = PWDATA[GPIO_W-1:0];
    PREADY     = ready_s;
    PSLVERR    = ready_s && err_s;
  end

  always_comb begin
    if (access_s && !ready_s) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = 4'd0;
    end
  end

  // Read mux; SET/CLR and unmapped offsets read as zero.
  always_comb begin
    case (idx_s)
      IDX_OUT:   rdata_s = 32'(out_q);
      IDX_IN:    rdata_s = 32'(sync_out_s);
      IDX_IEN:   rdata_s = 32'(ien_q);
      IDX_ISTAT: rdata_s = 32'(istat_q);
      IDX_ID:    rdata_s = ID_VALUE;
      default:   rdata_s = 32'd0;
    endcase
    if (access_s && !PWRITE && !unmapped_s) begin
      PRDATA = rdata_s;
    end else begin
      PRDATA = 32'd0;
    end
  end

  always_comb begin
    sync_d[0] = GPIO_IN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_out_s = sync_q[SYNC_STAGES-1];
    prev_d     = sync_out_s;
    rise_s     = sync_out_s & ~prev_q;
  end

  // Register updates; a rise on the same edge as a W1C keeps the bit set.
  always_comb begin
    out_d = out_q;
    ien_d = ien_q;
    clr_s = '0;
    if (commit_s) begin
      case (idx_s)
        IDX_OUT:   out_d = wdata_s;
        IDX_SET:   out_d = out_q | wdata_s;
        IDX_CLR:   out_d = out_q & ~wdata_s;
        IDX_IEN:   ien_d = wdata_s;
        IDX_ISTAT: clr_s = wdata_s;
        default:   out_d = out_q;
      endcase
    end else begin
      clr_s = '0;
    end
    istat_d = (istat_q & ~clr_s) | rise_s;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_q   <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      prev_q  <= '0;
      wcnt_q  <= 4'd0;
      sync_q  <= '0;
    end else begin
      out_q   <= out_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      prev_q  <= prev_d;
      wcnt_q  <= wcnt_d;
      sync_q  <= sync_d;
    end
  end

  assign GPIO_OUT = out_q;
  assign IRQ      = |(istat_q & ien_q);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Bench for apb_gpio_bank: a zero-wait instance and a 3-wait instance share one APB bus
// with separate selects; directed vectors plus hand-timed corner sequences.
module tb_apb_gpio_bank;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [7:0]  PADDR;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3, irq0, irq3;
  logic [15:0] gpio_out0, gpio_out3, gpio_in0, gpio_in3;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio_bank #(.GPIO_W(16), .ADDR_W(8), .WAIT_STATES(0), .SYNC_STAGES(2)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .GPIO_OUT(gpio_out0), .GPIO_IN(gpio_in0), .IRQ(irq0));

  apb_gpio_bank #(.GPIO_W(16), .ADDR_W(8), .WAIT_STATES(3), .SYNC_STAGES(2)) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel3), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
    .GPIO_OUT(gpio_out3), .GPIO_IN(gpio_in3), .IRQ(irq3));

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 32'h0;
  endtask

  // One full APB transfer on the selected instance; waits = ACCESS cycles with PREADY low.
  task automatic apb_xfer(input int which, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int waits);
    logic done;
    logic rdy;
    done = 1'b0; waits = 0; rd = 32'h0; err = 1'b0;
    @(posedge PCLK); #1;
    PADDR = addr; PWRITE = wr; PWDATA = wd; PENABLE = 1'b0;
    if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge PCLK);
      rdy = (which == 0) ? pready0 : pready3;
      if (rdy) begin
        done = 1'b1;
        rd   = (which == 0) ? prdata0 : prdata3;
        err  = (which == 0) ? pslverr0 : pslverr3;
      end else begin
        waits++;
      end
      @(posedge PCLK);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: got no PREADY within 20 cycles expected PREADY");
    end
    #1;
    bus_idle();
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;

  initial begin
    vecs[0]  = '{1'b1, 8'h00, 32'hFFFF_A5A5, 32'h0,          1'b0, 16'hA5A5};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         32'h0000_A5A5,  1'b0, 16'hA5A5};
    vecs[2]  = '{1'b1, 8'h00, 32'h0000_00F0, 32'h0,          1'b0, 16'h00F0};
    vecs[3]  = '{1'b1, 8'h08, 32'h0000_000F, 32'h0,          1'b0, 16'h00FF};
    vecs[4]  = '{1'b1, 8'h0C, 32'h0000_00F0, 32'h0,          1'b0, 16'h000F};
    vecs[5]  = '{1'b0, 8'h08, 32'h0,         32'h0,          1'b0, 16'h000F};
    vecs[6]  = '{1'b0, 8'h0C, 32'h0,         32'h0,          1'b0, 16'h000F};
    vecs[7]  = '{1'b1, 8'h04, 32'h0000_1234, 32'h0,          1'b1, 16'h000F};
    vecs[8]  = '{1'b1, 8'h18, 32'h0000_0000, 32'h0,          1'b1, 16'h000F};
    vecs[9]  = '{1'b0, 8'h20, 32'h0,         32'h0,          1'b1, 16'h000F};
    vecs[10] = '{1'b0, 8'h18, 32'h0,         32'h4750_0010,  1'b0, 16'h000F};
    vecs[11] = '{1'b1, 8'h1C, 32'h0000_FFFF, 32'h0,          1'b1, 16'h000F};
    vecs[12] = '{1'b0, 8'h10, 32'h0,         32'h0,          1'b0, 16'h000F};

    bus_idle();
    gpio_in0 = 16'h0; gpio_in3 = 16'h0;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_gpio_out0", 32'(gpio_out0), 32'h0);
    check("reset_irq0", 32'(irq0), 32'h0);
    check("reset_gpio_out3", 32'(gpio_out3), 32'h0);
    check("idle_pready0", 32'(pready0), 32'h0);
    PRESETn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, waits);
      check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'd0);
      check($sformatf("vec%0d_gpio_out", i), 32'(gpio_out0), 32'(vecs[i].exp_out));
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      end
    end

    // Input sync, edge capture and interrupt masking.
    @(negedge PCLK);
    gpio_in0 = 16'h0003;
    apb_xfer(0, 1'b0, 8'h04, 32'h0, rd, err, waits);
    check("in_after_sync", rd, 32'h0000_0003);
    apb_xfer(0, 1'b0, 8'h14, 32'h0, rd, err, waits);
    check("istat_captured", rd, 32'h0000_0003);
    @(negedge PCLK);
    check("irq_masked", 32'(irq0), 32'h0);
    apb_xfer(0, 1'b1, 8'h10, 32'h0000_0001, rd, err, waits);
    @(negedge PCLK);
    check("irq_enabled", 32'(irq0), 32'h1);
    apb_xfer(0, 1'b1, 8'h14, 32'h0000_0001, rd, err, waits);
    apb_xfer(0, 1'b0, 8'h14, 32'h0, rd, err, waits);
    check("istat_w1c", rd, 32'h0000_0002);
    @(negedge PCLK);
    check("irq_after_w1c", 32'(irq0), 32'h0);

    // Re-arm bit0, then time a fresh rise onto the W1C commit edge.
    gpio_in0 = 16'h0002; repeat (4) @(posedge PCLK);
    gpio_in0 = 16'h0003; repeat (4) @(posedge PCLK);
    gpio_in0 = 16'h0002; repeat (4) @(posedge PCLK);
    apb_xfer(0, 1'b0, 8'h14, 32'h0, rd, err, waits);
    check("istat_rearmed", rd, 32'h0000_0003);
    gpio_in0 = 16'h0002; repeat (4) @(posedge PCLK);
    #1 gpio_in0 = 16'h0003;
    @(posedge PCLK); #1;
    PADDR = 8'h14; PWRITE = 1'b1; PWDATA = 32'h0000_0001; psel0 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("setwins_pready", 32'(pready0), 32'h1);
    @(posedge PCLK); #1;
    bus_idle();
    apb_xfer(0, 1'b0, 8'h14, 32'h0, rd, err, waits);
    check("istat_set_wins", rd, 32'h0000_0003);
    apb_xfer(0, 1'b1, 8'h14, 32'h0000_0001, rd, err, waits);
    apb_xfer(0, 1'b0, 8'h14, 32'h0, rd, err, waits);
    check("istat_plain_clear", rd, 32'h0000_0002);

    // Wait-state instance.
    apb_xfer(3, 1'b0, 8'h18, 32'h0, rd, err, waits);
    check("ws3_id_waits", 32'(waits), 32'd3);
    check("ws3_id_prdata", rd, 32'h4750_0010);
    check("ws3_id_pslverr", 32'(err), 32'h0);
    apb_xfer(3, 1'b1, 8'h00, 32'h0000_1234, rd, err, waits);
    check("ws3_wr_waits", 32'(waits), 32'd3);
    check("ws3_wr_gpio_out", 32'(gpio_out3), 32'h0000_1234);
    apb_xfer(3, 1'b1, 8'h04, 32'h0000_FFFF, rd, err, waits);
    check("ws3_wr_in_err", 32'(err), 32'h1);
    check("ws3_wr_in_out", 32'(gpio_out3), 32'h0000_1234);

    // PSEL dropped before PREADY: no write, counter restarts.
    @(posedge PCLK); #1;
    PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'h0000_5555; psel3 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 bus_idle();
    @(negedge PCLK);
    check("abort_gpio_out", 32'(gpio_out3), 32'h0000_1234);
    apb_xfer(3, 1'b0, 8'h00, 32'h0, rd, err, waits);
    check("abort_restart_waits", 32'(waits), 32'd3);
    check("abort_readback", rd, 32'h0000_1234);

    // Reset during a wait-state write.
    @(posedge PCLK); #1;
    PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'h0000_BEEF; psel3 = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("rst_mid_pready", 32'(pready3), 32'h0);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_gpio_out", 32'(gpio_out3), 32'h0);
    check("rst_mid_wcnt", 32'(u_dut3.wcnt_q), 32'h0);
    bus_idle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(3, 1'b0, 8'h00, 32'h0, rd, err, waits);
    check("rst_mid_readback", rd, 32'h0);
    check("rst_mid_gpio_out_after", 32'(gpio_out3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
